// File: rtl/dff_arb_pkg.sv
// Shared types and the round-robin pick helper for the DFF write arbiter.
// rr_pick works on a fixed-width vector so any NUM_REQ up to MAX_REQ can reuse it.
package dff_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int MAX_REQ     = 32;
    localparam int MAX_ID_W    = $clog2(MAX_REQ);

    // One-hot pick of the first set bit at or above ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int ptr,
                                                   input int n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if ((k < n) && (idx < n) && !found && req[idx[MAX_ID_W-1:0]]) begin
                pick[idx[MAX_ID_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or after ptr.
module rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
        gnt = NUM_REQ'(rr_pick(req_ext, int'(ptr), NUM_REQ));
    end

endmodule

// File: rtl/dff_wr_arbiter.sv
// One shared WIDTH-bit register written by NUM_REQ clients under round-robin
// arbitration, with an optional bounded lock that keeps ownership for a burst.
module dff_wr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WIDTH    = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       locked,
    output logic [15:0]                wr_cnt
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, ptr_inc;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [NUM_REQ-1:0] rr_gnt;
    logic               accept;
    logic [ID_W-1:0]    win_id;
    logic [WIDTH-1:0]   win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    // While locked, owner_id names the lock holder; nobody else may be granted.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (state == ARB) gnt = rr_gnt;
            else              gnt[owner_id] = req[owner_id];
        end
    end

    // Only the granted lane is selected, so X on idle lanes never reaches q.
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id   = ID_W'(i);
                win_data = wdata[i*WIDTH +: WIDTH];
            end
        end
        accept  = |gnt;
        ptr_inc = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;
        if (accept) begin
            case (state)
                ARB: begin
                    ptr_nxt = ptr_inc;
                    // With LOCK_MAX=1 the lock expires on the very write that took it.
                    if (lock[win_id] && (LOCK_MAX > 1)) begin
                        state_nxt    = LOCKED;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (!lock[win_id] || (lock_cnt == CNT_W'(LOCK_MAX - 1))) begin
                        state_nxt    = ARB;
                        ptr_nxt      = ptr_inc;
                        lock_cnt_nxt = '0;
                    end else begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            lock_cnt <= '0;
            q        <= '0;
            owner_id <= '0;
            wr_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (accept) begin
                q        <= win_data;
                owner_id <= win_id;
                wr_cnt   <= wr_cnt + 16'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Directed bench for dff_wr_arbiter: reset, single write, round-robin order,
// lock burst, forced lock release and reset during a lock.
module tb_dff_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic [1:0]  owner_id;
    logic        locked;
    logic [15:0] wr_cnt;

    int vec_cnt;
    int err_cnt;

    logic [3:0]  exp_q;
    logic [1:0]  exp_owner;
    logic [15:0] exp_cnt;

    dff_wr_arbiter #(
        .NUM_REQ  (4),
        .WIDTH    (4),
        .LOCK_MAX (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .owner_id (owner_id),
        .locked   (locked),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are already applied; check the combinational grant, clock once,
    // then check registered outputs against the bench's own model.
    task automatic step(input string tag, input logic [3:0] exp_gnt, input logic exp_locked);
        int idx;
        #1;
        check_val({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_val({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
        if (exp_gnt != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (exp_gnt[i]) idx = i;
            exp_q     = wdata[idx*4 +: 4];
            exp_owner = 2'(idx);
            exp_cnt   = exp_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".q"}, 32'(q), 32'(exp_q));
        check_val({tag, ".owner"}, 32'(owner_id), 32'(exp_owner));
        check_val({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(exp_cnt));
        check_val({tag, ".locked"}, 32'(locked), 32'(exp_locked));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_val({tag, ".rst_gnt0"}, 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, ".rst_gnt1"}, 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, ".rst_q"}, 32'(q), 32'd0);
        check_val({tag, ".rst_wr_cnt"}, 32'(wr_cnt), 32'd0);
        check_val({tag, ".rst_locked"}, 32'(locked), 32'd0);
        check_val({tag, ".rst_owner"}, 32'(owner_id), 32'd0);
        rst       = 1'b0;
        exp_q     = 4'h0;
        exp_owner = 2'd0;
        exp_cnt   = 16'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        req     = 4'hF;
        lock    = 4'h0;
        wdata   = 16'h4321;

        // T1: reset with every requester pending
        do_reset("t1");

        // T2: single writer, idle lanes carry X
        req          = 4'b0100;
        wdata        = 'x;
        wdata[11:8]  = 4'hA;
        step("t2", 4'b0100, 1'b0);
        req = 4'b0000;
        step("t2_idle", 4'b0000, 1'b0);

        // T3: round-robin from ptr=0
        wdata = 16'h4321;
        do_reset("t3");
        req = 4'hF;
        step("t3_w0", 4'b0001, 1'b0);
        step("t3_w1", 4'b0010, 1'b0);
        step("t3_w2", 4'b0100, 1'b0);
        step("t3_w3", 4'b1000, 1'b0);
        step("t3_w4", 4'b0001, 1'b0);

        // T4: lane 1 locks, others stall, owner idle keeps the lock
        lock  = 4'b0010;
        wdata = 16'h4351;
        step("t4_l1", 4'b0010, 1'b1);
        req = 4'b1101;
        step("t4_idle", 4'b0000, 1'b1);
        req   = 4'hF;
        wdata = 16'h4371;
        step("t4_l2", 4'b0010, 1'b1);
        lock  = 4'b0000;
        wdata = 16'h4391;
        step("t4_rel", 4'b0010, 1'b0);
        step("t4_next", 4'b0100, 1'b0);

        // T5: lane 3 holds lock until the burst limit forces release
        lock  = 4'b1000;
        wdata = 16'h5321;
        step("t5_w1", 4'b1000, 1'b1);
        wdata = 16'h6321;
        step("t5_w2", 4'b1000, 1'b1);
        wdata = 16'h7321;
        step("t5_w3", 4'b1000, 1'b1);
        wdata = 16'h8321;
        step("t5_w4", 4'b1000, 1'b0);
        step("t5_next", 4'b0001, 1'b0);

        // T6: reset in the middle of a lock
        lock = 4'b0010;
        step("t6_l1", 4'b0010, 1'b1);
        do_reset("t6");
        lock = 4'b0000;
        step("t6_after", 4'b0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
